// File: rtl/tsc_sample_capture.sv
// Trigger-surround capture controller: paced ADC request/ready initiator feeding
// a sample ring, freezing POST_DEPTH samples after trigger and reading the window oldest-first.
module tsc_sample_capture #(
  parameter int PRE_DEPTH  = 16,
  parameter int POST_DEPTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int SAMPLE_DIV = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       trigger,
  output logic       adc_req,
  input  logic       adc_rdy,
  input  logic [7:0] adc_dat,
  input  logic       rd_en,
  output logic [7:0] rd_dat,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  localparam int CNT_W = 16;
  localparam int SC_W  = $clog2(PRE_DEPTH + 1);
  localparam int PC_W  = $clog2(POST_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST, DONE} state_t;
  typedef enum logic [1:0] {E_OFF, E_WAIT, E_GAP} eng_t;

  state_t            state_reg, state_next;
  eng_t              eng_reg, eng_next;
  logic [CNT_W-1:0]  ecnt_reg, ecnt_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W-1:0] rd_cnt_reg, rd_cnt_next;
  logic [SC_W-1:0]   smp_cnt_reg, smp_cnt_next;
  logic [PC_W-1:0]   post_cnt_reg, post_cnt_next;
  logic              adc_req_next;
  logic              timeout_err_next;
  logic              rd_valid_next;
  logic              wr_en;
  logic              rd_fire;
  logic              complete;
  logic              issue;

  logic [7:0] ring [DEPTH];

  assign busy = (state_reg == PRE_FILL) || (state_reg == WAIT_TRIG) || (state_reg == POST);
  assign done = (state_reg == DONE);

  always_comb begin
    state_next       = state_reg;
    eng_next         = eng_reg;
    ecnt_next        = ecnt_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    rd_cnt_next      = rd_cnt_reg;
    smp_cnt_next     = smp_cnt_reg;
    post_cnt_next    = post_cnt_reg;
    timeout_err_next = timeout_err;
    adc_req_next     = 1'b0;
    rd_valid_next    = 1'b0;
    wr_en            = 1'b0;
    rd_fire          = 1'b0;
    complete         = 1'b0;
    issue            = 1'b0;

    // ecnt==0 is the adc_req cycle; the response window is ecnt 1..TIMEOUT-1
    case (eng_reg)
      E_WAIT: begin
        if (ecnt_reg != '0 && adc_rdy) begin
          wr_en    = 1'b1;
          complete = 1'b1;
        end else if (ecnt_reg == CNT_W'(TIMEOUT - 1)) begin
          timeout_err_next = 1'b1;
          complete         = 1'b1;
        end else begin
          ecnt_next = ecnt_reg + 1'b1;
        end
      end
      E_GAP: begin
        if (ecnt_reg == CNT_W'(SAMPLE_DIV - 1)) issue = 1'b1;
        else ecnt_next = ecnt_reg + 1'b1;
      end
      default: ;
    endcase

    // next request lands SAMPLE_DIV cycles after the completing cycle
    if (complete) begin
      if (SAMPLE_DIV == 1) begin
        issue = 1'b1;
      end else begin
        eng_next  = E_GAP;
        ecnt_next = CNT_W'(1);
      end
    end
    if (issue) begin
      adc_req_next = 1'b1;
      eng_next     = E_WAIT;
      ecnt_next    = '0;
    end
    if (wr_en) wr_ptr_next = wr_ptr_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next       = PRE_FILL;
          timeout_err_next = 1'b0;
          wr_ptr_next      = '0;
          smp_cnt_next     = '0;
          post_cnt_next    = '0;
          rd_cnt_next      = '0;
          adc_req_next     = 1'b1;
          eng_next         = E_WAIT;
          ecnt_next        = '0;
        end
      end
      PRE_FILL: begin
        if (wr_en) begin
          smp_cnt_next = smp_cnt_reg + 1'b1;
          if (smp_cnt_reg == SC_W'(PRE_DEPTH - 1)) state_next = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (trigger) begin
          state_next    = POST;
          post_cnt_next = '0;
        end
      end
      POST: begin
        if (wr_en) begin
          post_cnt_next = post_cnt_reg + 1'b1;
          if (post_cnt_reg == PC_W'(POST_DEPTH - 1)) begin
            state_next   = DONE;
            rd_ptr_next  = wr_ptr_reg + 1'b1;
            rd_cnt_next  = '0;
            eng_next     = E_OFF;
            ecnt_next    = '0;
            adc_req_next = 1'b0;
          end
        end
      end
      DONE: begin
        if (rd_en) begin
          rd_fire       = 1'b1;
          rd_valid_next = 1'b1;
          rd_ptr_next   = rd_ptr_reg + 1'b1;
          rd_cnt_next   = rd_cnt_reg + 1'b1;
          if (rd_cnt_reg == ADDR_W'(DEPTH - 1)) begin
            state_next  = IDLE;
            rd_cnt_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      eng_reg      <= E_OFF;
      ecnt_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_cnt_reg   <= '0;
      smp_cnt_reg  <= '0;
      post_cnt_reg <= '0;
      adc_req      <= 1'b0;
      timeout_err  <= 1'b0;
      rd_valid     <= 1'b0;
      rd_dat       <= '0;
    end else begin
      state_reg    <= state_next;
      eng_reg      <= eng_next;
      ecnt_reg     <= ecnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      rd_cnt_reg   <= rd_cnt_next;
      smp_cnt_reg  <= smp_cnt_next;
      post_cnt_reg <= post_cnt_next;
      adc_req      <= adc_req_next;
      timeout_err  <= timeout_err_next;
      rd_valid     <= rd_valid_next;
      if (rd_fire) rd_dat <= ring[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ring[wr_ptr_reg] <= adc_dat;
  end

endmodule

// File: tb/tb_tsc_sample_capture.sv
// Directed bench for tsc_sample_capture: responder model returning its request index as data,
// expected window pushed at arm time and popped as each read returns.
module tb_tsc_sample_capture;
  localparam int DEPTH      = 32;
  localparam int SAMPLE_DIV = 4;
  localparam int TIMEOUT    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       trigger = 1'b0;
  logic       adc_req;
  logic       adc_rdy;
  logic [7:0] adc_dat;
  logic       rd_en = 1'b0;
  logic [7:0] rd_dat;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       timeout_err;

  tsc_sample_capture dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trigger(trigger),
    .adc_req(adc_req), .adc_rdy(adc_rdy), .adc_dat(adc_dat),
    .rd_en(rd_en), .rd_dat(rd_dat), .rd_valid(rd_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int val = 0;
  int req_count = 0;
  int rdy_count = 0;
  int last_req_cyc = 0;
  int last_rdy_cyc = 0;
  bit last_rdy_valid = 1'b0;
  int withhold_idx = -1;
  int wh_req_cyc = 0;
  int gap_q[$];
  logic [7:0] exp_q[$];

  // responder: data = request index, adc_rdy one cycle after adc_req unless withheld
  initial begin
    int idx;
    adc_rdy = 1'b0;
    adc_dat = 8'h00;
    forever begin
      @(negedge clk);
      if (adc_req === 1'b1) begin
        req_count++;
        last_req_cyc = cyc;
        idx = val;
        val++;
        if (last_rdy_valid) begin
          gap_q.push_back(cyc - last_rdy_cyc);
          last_rdy_valid = 1'b0;
        end
        if (idx == withhold_idx) begin
          wh_req_cyc = cyc;
        end else begin
          @(posedge clk); #1;
          adc_rdy = 1'b1;
          adc_dat = idx[7:0];
          @(negedge clk);
          rdy_count++;
          last_rdy_cyc = cyc;
          last_rdy_valid = 1'b1;
          @(posedge clk); #1;
          adc_rdy = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_arm(input logic with_trig);
    @(posedge clk); #1;
    arm = 1'b1;
    trigger = with_trig;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic pulse_trigger();
    @(posedge clk); #1;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_rdy(input string tag, input int target);
    int n = 0;
    while (rdy_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rdy_count >= target), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic read_window(input string tag);
    logic [7:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      @(negedge clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      $display("[TB] %s read %0d: rd_dat=%02h expected=%02h rd_valid=%0b", tag, i, rd_dat, exp, rd_valid);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_rd_dat"}, 32'(rd_dat), 32'(exp));
      if (i == DEPTH - 2) check({tag, "_done_before_last"}, 32'(done), 32'd1);
      if (i == DEPTH - 1) begin
        check({tag, "_done_after_last"}, 32'(done), 32'd0);
        check({tag, "_busy_after_last"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    int base, start, rc, t_to;

    // reset values
    #2;
    check("rst_adc_req", 32'(adc_req), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_dat", 32'(rd_dat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first request the cycle after arm, then async reset mid-cycle
    pulse_arm(1'b0);
    check("arm_first_req", 32'(adc_req), 32'd1);
    check("arm_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_adc_req", 32'(adc_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // basic capture, trigger after 20 samples
    base = val;
    start = rdy_count;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(base + 4 + i));
    pulse_arm(1'b0);
    wait_rdy("t2_wait20", start + 20);
    pulse_trigger();
    wait_done("t2_done");
    check("t2_samples", 32'(rdy_count - start), 32'd36);
    rc = req_count;
    repeat (10) @(negedge clk);
    check("t2_no_req_in_done", 32'(req_count), 32'(rc));
    read_window("t2");

    // trigger held during early PRE_FILL is ignored
    base = val;
    start = rdy_count;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(base + i));
    pulse_arm(1'b1);
    wait_rdy("t3_wait5", start + 5);
    @(posedge clk); #1;
    trigger = 1'b0;
    check("t3_still_busy", 32'(busy), 32'd1);
    wait_rdy("t3_wait16", start + 16);
    pulse_trigger();
    wait_done("t3_done");
    read_window("t3");

    // third request withheld -> timeout, no write, next request paced
    base = val;
    start = rdy_count;
    withhold_idx = base + 2;
    exp_q.push_back(8'(base));
    exp_q.push_back(8'(base + 1));
    for (int i = 3; i <= 32; i++) exp_q.push_back(8'(base + i));
    pulse_arm(1'b0);
    begin
      int n = 0;
      while (timeout_err !== 1'b1 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    t_to = cyc;
    check("t4_timeout_set", 32'(timeout_err), 32'd1);
    check("t4_timeout_latency", 32'(t_to - wh_req_cyc), 32'(TIMEOUT));
    rc = req_count;
    begin
      int n = 0;
      while (req_count == rc && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("t4_next_req_spacing", 32'(last_req_cyc - wh_req_cyc), 32'(TIMEOUT - 1 + SAMPLE_DIV));
    wait_rdy("t4_wait16", start + 16);
    pulse_trigger();
    wait_done("t4_done");
    check("t4_timeout_sticky", 32'(timeout_err), 32'd1);
    read_window("t4");
    withhold_idx = -1;
    check("t4_sticky_in_idle", 32'(timeout_err), 32'd1);

    // reset during POST, then no requests until a new arm
    start = rdy_count;
    pulse_arm(1'b0);
    check("t5_arm_clears_err", 32'(timeout_err), 32'd0);
    wait_rdy("t5_wait16", start + 16);
    pulse_trigger();
    wait_rdy("t5_wait_post", start + 18);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_req", 32'(adc_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rc = req_count;
    repeat (30) @(negedge clk);
    check("t5_no_req_after_rst", 32'(req_count), 32'(rc));
    check("t5_idle_busy", 32'(busy), 32'd0);

    // rd_en in IDLE and WAIT_TRIG is ignored; request pacing after adc_rdy
    @(posedge clk); #1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    check("t6_rd_idle", 32'(rd_valid), 32'd0);
    base = val;
    start = rdy_count;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(base + i));
    pulse_arm(1'b0);
    wait_rdy("t6_wait2", start + 2);
    gap_q.delete();
    wait_rdy("t6_wait16", start + 16);
    @(posedge clk); #1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    check("t6_rd_wait_trig", 32'(rd_valid), 32'd0);
    pulse_trigger();
    wait_done("t6_done");
    check("t6_gap_count", 32'(gap_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && gap_q.size() > 0; i++) begin
      check("t6_req_gap", 32'(gap_q.pop_front()), 32'(SAMPLE_DIV));
    end
    read_window("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
